// File: rtl/con_pkg.sv
// Shared definitions for the BCD <-> binary converters: FSM states and
// double-dabble digit constants.
package con_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;
    localparam logic [3:0] DABBLE_THRESH = 4'd8;
    localparam logic [3:0] DABBLE_ADJ    = 4'd3;
endpackage

// File: rtl/con12to8_seq_if.sv
// Start/done handshake and data bus of the BCD-to-binary converter.
interface con12to8_seq_if #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 8
);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  busy;
    logic                  done;
    logic [BIN_W-1:0]      bin_out;
    logic                  ovf;
    logic                  err;

    modport master (output start, bcd_in, input busy, done, bin_out, ovf, err);
    modport slave  (input start, bcd_in, output busy, done, bin_out, ovf, err);
endinterface

// File: rtl/bcd_digit_adj.sv
// Reverse double-dabble correction for one BCD digit after a right shift.
module bcd_digit_adj
    import con_pkg::*;
(
    input  logic [3:0] d,
    output logic [3:0] q
);
    assign q = (d >= DABBLE_THRESH) ? d - DABBLE_ADJ : d;
endmodule

// File: rtl/con12to8_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble), one bit per cycle.
// Optional: define CON12TO8_SAT_EN to saturate bin_out to all ones on overflow.
module con12to8_seq
    import con_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int ACC_W  = 10,
    parameter int BIN_W  = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    con12to8_seq_if.slave   bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (ACC_W > 1) ? $clog2(ACC_W) : 1;

    state_t             state;
    logic [BCD_W-1:0]   bcd;
    logic [BCD_W-1:0]   bcd_shr;
    logic [BCD_W-1:0]   bcd_adj;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               in_err;
    logic               ovf_nxt;
    logic [BIN_W-1:0]   bin_nxt;

    // The shift moves the BCD LSB into the accumulator MSB; only the BCD
    // digits need correcting afterwards.
    assign bcd_shr = bcd >> 1;
    assign acc_nxt = {bcd[0], acc[ACC_W-1:1]};

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (.d(bcd_shr[4*g +: 4]), .q(bcd_adj[4*g +: 4]));
    end

    always_comb begin
        in_err = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            if (bus.bcd_in[4*i +: 4] > BCD_DIGIT_MAX) in_err = 1'b1;
    end

    assign ovf_nxt = (acc_nxt >> BIN_W) != '0;
`ifdef CON12TO8_SAT_EN
    assign bin_nxt = ovf_nxt ? '1 : acc_nxt[BIN_W-1:0];
`else
    assign bin_nxt = acc_nxt[BIN_W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            bcd         <= '0;
            acc         <= '0;
            cnt         <= '0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.bin_out <= '0;
            bus.ovf     <= 1'b0;
            bus.err     <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    bcd      <= bus.bcd_in;
                    acc      <= '0;
                    cnt      <= '0;
                    bus.ovf  <= 1'b0;
                    bus.err  <= in_err;
                    bus.busy <= 1'b1;
                    if (in_err) begin
                        bus.bin_out <= '0;
                        state       <= DONE;
                    end else begin
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd <= bcd_adj;
                    acc <= acc_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(ACC_W - 1)) begin
                        bus.bin_out <= bin_nxt;
                        bus.ovf     <= ovf_nxt;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    bus.done <= 1'b1;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
